// File: rtl/sub16u_serial.sv
// sub16u_serial: digit-serial exact unsigned subtractor, O = (A - B) mod 2^(WIDTH+1).
// Processes DIGIT bits per cycle, LSB first, with the borrow rippling between digits
// through a register. Operands are accepted with a valid/ready handshake, and the
// result is returned with a valid/ready handshake.
//   clk, rst   : single rising-edge clock, asynchronous active-high reset
//   in_valid   : A/B valid          in_ready  : block idle, can accept operands
//   A, B       : minuend/subtrahend out_valid : O holds a completed result
//   out_ready  : consumer takes O   O         : {borrow, difference}
module sub16u_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   O
);

    localparam int unsigned N     = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Parameter legality
    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("sub16u_serial: DIGIT must be >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
            $error("sub16u_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     o_q, o_d;
    logic               out_valid_q, out_valid_d;

    // Current digit difference; the top bit is the borrow out of the digit
    logic [DIGIT:0]     digit_diff;
    logic [WIDTH-1:0]   res_shift;

    always_comb begin
        digit_diff = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};
        // New digit enters the result register from the top
        res_shift  = WIDTH'({digit_diff[DIGIT-1:0], res_q} >> DIGIT);
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                res_d    = res_shift;
                borrow_d = digit_diff[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    o_d         = {digit_diff[DIGIT], res_shift};
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Ready is a decode of the state register, held low throughout reset
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign O         = o_q;

endmodule

// File: tb/tb_sub16u_serial.sv
// Testbench for sub16u_serial: three instances with DIGIT = 1, 4 and 16.
// Directed scenarios run on the DIGIT=4 instance (plus latency checks on the
// others), followed by a concurrent random run on all three against (A-B) mod 2^17.
module tb_sub16u_serial;

    logic        clk;
    logic        rst;
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [15:0] a    [3];
    logic [15:0] b    [3];
    logic [16:0] o    [3];

    int n_cmp;
    int n_bad;

    sub16u_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .O(o[0])
    );
    sub16u_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .O(o[1])
    );
    sub16u_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]), .B(b[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .O(o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One operation on instance idx: accept, measure latency, check result,
    // and optionally complete the output handshake.
    task automatic do_op(input int idx, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [16:0] exp, input int exp_lat, input bit release_out,
                         input string name);
        int lat;
        @(negedge clk);
        a[idx]  = aa;
        b[idx]  = bb;
        iv[idx] = 1'b1;
        n_cmp++;
        if (ir[idx] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_in_ready got %b want 1", name, ir[idx]);
        end
        @(posedge clk); #1;
        iv[idx] = 1'b0;
        lat = 0;
        while (ov[idx] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (o[idx] !== exp) begin
            n_bad++;
            $display("FAIL %s_result got %05h want %05h", name, o[idx], exp);
        end
        if (release_out) begin
            @(negedge clk);
            ordy[idx] = 1'b1;
            @(posedge clk); #1;
            ordy[idx] = 1'b0;
            n_cmp++;
            if (ov[idx] !== 1'b0 || ir[idx] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1", name, ov[idx], ir[idx]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ov[i] !== 1'b0 || o[i] !== 17'h0 || ir[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_%0d got ov=%b o=%05h ir=%b want 0/00000/0", i, ov[i], o[i], ir[i]);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ir[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_in_ready got %b want 1", ir[1]);
        end
    endtask

    task automatic test_basic();
        do_op(1, 16'h1234, 16'h0234, 17'h01000, 4, 1'b1, "basic");
    endtask

    task automatic test_borrow();
        do_op(1, 16'h0000, 16'h0001, 17'h1FFFF, 4, 1'b1, "borrow_wrap");
        do_op(1, 16'h1000, 16'h0001, 17'h00FFF, 4, 1'b1, "borrow_ripple");
        do_op(1, 16'h0000, 16'hFFFF, 17'h10001, 4, 1'b1, "zero_minus_max");
    endtask

    task automatic test_extremes();
        do_op(1, 16'hFFFF, 16'hFFFF, 17'h00000, 4, 1'b1, "equal");
        do_op(1, 16'hFFFF, 16'h0000, 17'h0FFFF, 4, 1'b1, "max_minus_zero");
    endtask

    task automatic test_digit_variants();
        do_op(0, 16'h0000, 16'hFFFF, 17'h10001, 16, 1'b1, "bitserial");
        do_op(0, 16'hA5A5, 16'h5A5A, 17'h04B4B, 16, 1'b1, "bitserial_b");
        do_op(2, 16'h0000, 16'hFFFF, 17'h10001, 1, 1'b1, "fullwidth");
        do_op(2, 16'h1000, 16'h0001, 17'h00FFF, 1, 1'b1, "fullwidth_b");
    endtask

    task automatic test_hold_stall();
        int lat;
        do_op(1, 16'h1234, 16'h0234, 17'h01000, 4, 1'b0, "hold");
        @(negedge clk);
        a[1] = 16'h9999; b[1] = 16'h1111; iv[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ov[1] !== 1'b1 || o[1] !== 17'h01000 || ir[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable_%0d got ov=%b o=%05h ir=%b want 1/01000/0", k, ov[1], o[1], ir[1]);
            end
        end
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        n_cmp++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_to_idle got ov=%b ir=%b want 0/1", ov[1], ir[1]);
        end
        @(posedge clk); #1;
        iv[1] = 1'b0;
        n_cmp++;
        if (ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_new_accept got in_ready=%b want 0", ir[1]);
        end
        lat = 0;
        while (ov[1] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4 || o[1] !== 17'h08888) begin
            n_bad++;
            $display("FAIL hold_next_op got lat=%0d o=%05h want 4/08888", lat, o[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        // Previous result still held; drain it first.
        @(negedge clk);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        a[1] = 16'h1234; b[1] = 16'h0234; iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ov[1] !== 1'b0 || o[1] !== 17'h0 || ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset got ov=%b o=%05h ir=%b want 0/00000/0", ov[1], o[1], ir[1]);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ir[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset_ready got %b want 0", ir[1]);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL midrun_no_pulse_%0d got ov=%b ir=%b want 0/1", k, ov[1], ir[1]);
            end
        end
        do_op(1, 16'h0005, 16'h0007, 17'h1FFFE, 4, 1'b1, "after_reset");
    endtask

    // Concurrent random traffic on all three instances with input and output stalls
    task automatic test_random();
        localparam int TARGET = 800;
        logic [16:0] exp_v [3];
        bit          pend  [3];
        bit          acc   [3];
        int          done  [3];
        int          taken [3];
        int          cyc;
        bit          busy;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; acc[i] = 1'b0; done[i] = 0; taken[i] = 0; exp_v[i] = '0;
        end
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    iv[i]  = 1'b0;
                    acc[i] = 1'b0;
                end
                if (!iv[i] && taken[i] < TARGET) begin
                    iv[i] = ($urandom_range(0, 3) != 0);
                    a[i]  = 16'($urandom);
                    b[i]  = 16'($urandom);
                end
                ordy[i] = ($urandom_range(0, 2) != 0);
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && ordy[i]) begin
                    n_cmp++;
                    if (!pend[i] || o[i] !== exp_v[i]) begin
                        n_bad++;
                        $display("FAIL random_d%0d_op%0d got %05h want %05h pend=%b", i, done[i], o[i], exp_v[i], pend[i]);
                    end
                    pend[i] = 1'b0;
                    done[i]++;
                end
                if (iv[i] && ir[i]) begin
                    if (pend[i]) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL random_d%0d_accept_while_pending got accept want none", i);
                    end
                    exp_v[i] = 17'({1'b0, a[i]} - {1'b0, b[i]});
                    pend[i]  = 1'b1;
                    acc[i]   = 1'b1;
                    taken[i]++;
                end
            end
            busy = 1'b0;
            for (int i = 0; i < 3; i++)
                if (taken[i] < TARGET || pend[i]) busy = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0;
            n_cmp++;
            if (done[i] != TARGET || taken[i] != TARGET || pend[i]) begin
                n_bad++;
                $display("FAIL random_d%0d_count got done=%0d taken=%0d want %0d (cycles %0d)", i, done[i], taken[i], TARGET, cyc);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_extremes();
        test_digit_variants();
        test_hold_stall();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
